// File: rtl/ed_alif_event_driver_if.sv
// Event handshake, timestep strobe and neuron-update bus shared between the
// ALIF event driver (slave) and whatever feeds it events and hosts the neuron (master).
interface ed_alif_event_driver_if #(
    parameter int V_WIDTH  = 12,
    parameter int WT_WIDTH = 8
);
    logic                       tick;
    logic                       ev_valid;
    logic                       ev_ready;
    logic signed [WT_WIDTH-1:0] ev_weight;
    logic                       nrn_enable;
    logic signed [V_WIDTH-1:0]  nrn_I_syn;
    logic                       nrn_input_event;
    logic [3:0]                 nrn_refract_cnt;
    logic                       nrn_spike;
    logic                       spike_out;
    logic [15:0]                spike_cnt;
    logic                       tick_overrun;

    modport slave (
        input  tick, ev_valid, ev_weight, nrn_spike,
        output ev_ready, nrn_enable, nrn_I_syn, nrn_input_event, nrn_refract_cnt,
               spike_out, spike_cnt, tick_overrun
    );

    modport master (
        output tick, ev_valid, ev_weight, nrn_spike,
        input  ev_ready, nrn_enable, nrn_I_syn, nrn_input_event, nrn_refract_cnt,
               spike_out, spike_cnt, tick_overrun
    );
endinterface

// File: rtl/ed_alif_event_driver.sv
// Synaptic-input driver for one event-driven ALIF neuron: accumulates weighted
// events per timestep, issues one neuron update per tick, owns refractory and spike output.
module ed_alif_event_driver #(
    parameter int V_WIDTH       = 12,
    parameter int WT_WIDTH      = 8,
    parameter int REFRACT_STEPS = 3
) (
    input logic                   clk,
    input logic                   rst,
    ed_alif_event_driver_if.slave bus
);

    typedef enum logic {ACCUM, ISSUE} state_t;

    localparam logic signed [V_WIDTH-1:0] ACC_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] ACC_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};
    localparam logic [3:0]                REFRACT_INIT = 4'(REFRACT_STEPS);

    // One guard bit is enough: a single weight never exceeds the accumulator range.
    function automatic logic signed [V_WIDTH-1:0] sat_add(
        input logic signed [V_WIDTH-1:0]  a,
        input logic signed [WT_WIDTH-1:0] w
    );
        logic signed [V_WIDTH:0] s;
        s = {a[V_WIDTH-1], a} + {{(V_WIDTH+1-WT_WIDTH){w[WT_WIDTH-1]}}, w};
        if (s[V_WIDTH] != s[V_WIDTH-1]) begin
            return s[V_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[V_WIDTH-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic signed [V_WIDTH-1:0]  acc_q, acc_d;
    logic                       flag_q, flag_d;
    logic signed [V_WIDTH-1:0]  i_syn_q, i_syn_d;
    logic                       in_ev_q, in_ev_d;
    logic [3:0]                 refr_q, refr_d;
    logic                       enable_q, enable_d;
    logic                       spike_q, spike_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       overrun_q, overrun_d;

    logic                       accept;
    logic signed [V_WIDTH-1:0]  acc_sum;

    assign bus.ev_ready        = (state_q == ACCUM);
    assign bus.nrn_enable      = enable_q;
    assign bus.nrn_I_syn       = i_syn_q;
    assign bus.nrn_input_event = in_ev_q;
    assign bus.nrn_refract_cnt = refr_q;
    assign bus.spike_out       = spike_q;
    assign bus.spike_cnt       = cnt_q;
    assign bus.tick_overrun    = overrun_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flag_d    = flag_q;
        i_syn_d   = i_syn_q;
        in_ev_d   = in_ev_q;
        refr_d    = refr_q;
        enable_d  = 1'b0;
        spike_d   = 1'b0;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        accept  = bus.ev_valid && (state_q == ACCUM);
        acc_sum = sat_add(acc_q, bus.ev_weight);

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d  = acc_sum;
                    flag_d = 1'b1;
                end
                // A same-cycle event is folded into the current step, not the next one.
                if (bus.tick) begin
                    i_syn_d  = accept ? acc_sum : acc_q;
                    in_ev_d  = flag_q | accept;
                    acc_d    = '0;
                    flag_d   = 1'b0;
                    enable_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.tick) begin
                    overrun_d = 1'b1;
                end
                if (bus.nrn_spike) begin
                    refr_d  = REFRACT_INIT;
                    spike_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end else if (refr_q != 4'd0) begin
                    refr_d = refr_q - 4'd1;
                end
                in_ev_d = 1'b0;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            flag_q    <= 1'b0;
            i_syn_q   <= '0;
            in_ev_q   <= 1'b0;
            refr_q    <= 4'd0;
            enable_q  <= 1'b0;
            spike_q   <= 1'b0;
            cnt_q     <= 16'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            flag_q    <= flag_d;
            i_syn_q   <= i_syn_d;
            in_ev_q   <= in_ev_d;
            refr_q    <= refr_d;
            enable_q  <= enable_d;
            spike_q   <= spike_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/ed_alif_event_driver.md
Name: ed_alif_event_driver

Overview:
- Drives the synaptic-input side of one event-driven ALIF neuron.
- Accepts weighted input spike events over a valid/ready handshake and accumulates them, with saturation, over one timestep.
- On each timestep strobe, issues exactly one single-cycle neuron update carrying the accumulated current, input-event flag and refractory count.
- Samples the neuron's combinational spike in that same cycle, then owns the refractory counter and the outgoing spike pulse.

Parameters:
- V_WIDTH, 12, width of the signed synaptic current; matches the neuron voltage width.
- WT_WIDTH, 8, width of the signed per-event weight.
- REFRACT_STEPS, 3, number of timesteps the neuron is held refractory after a spike; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  timestep strobe, one-cycle pulse.
- ev_valid  in  1  input event valid.
- ev_ready  out  1  input event ready.
- ev_weight  in  WT_WIDTH  signed event weight.
- nrn_enable  out  1  neuron update strobe.
- nrn_I_syn  out  V_WIDTH  signed accumulated current to the neuron.
- nrn_input_event  out  1  at least one event arrived this timestep.
- nrn_refract_cnt  out  4  refractory count presented to the neuron.
- nrn_spike  in  1  neuron spike; combinational and valid while nrn_enable=1.
- spike_out  out  1  registered one-cycle spike pulse.
- spike_cnt  out  16  total spikes since reset; wraps.
- tick_overrun  out  1  sticky error flag.

Behaviour:
- Reset: synchronous, active-high. Single clock domain.
  - FSM to ACCUM; accumulator=0; event flag=0.
  - nrn_enable=0, nrn_I_syn=0, nrn_input_event=0, nrn_refract_cnt=0.
  - spike_out=0, spike_cnt=0, tick_overrun=0.
  - ev_ready=1 from the first cycle after reset.
  - rst asserted in any state (including ISSUE) aborts that step; the neuron sees no further enable.
- FSM has two states: ACCUM and ISSUE.
- ACCUM:
  - ev_ready=1. An event is accepted on ev_valid & ev_ready.
  - On acceptance: acc <= sat(acc + sext(ev_weight)), clamped to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1]; event flag <= 1.
  - On tick:
    - nrn_I_syn <= acc, including any event accepted in the same cycle, saturated.
    - nrn_input_event <= flag, or 1 if an event is accepted that cycle.
    - acc <= 0, flag <= 0, go to ISSUE.
- ISSUE (exactly one cycle):
  - nrn_enable=1 (registered, asserted only in this cycle). ev_ready=0.
  - nrn_I_syn, nrn_input_event and nrn_refract_cnt are stable for the whole cycle.
  - nrn_spike is sampled in this cycle.
  - Next cycle:
    - If nrn_spike=1: nrn_refract_cnt <= REFRACT_STEPS; spike_out <= 1 for one cycle; spike_cnt += 1.
    - Else if nrn_refract_cnt != 0: nrn_refract_cnt decrements by 1.
    - nrn_input_event <= 0; state returns to ACCUM.
- Timing:
  - Latency from tick to nrn_enable: 1 cycle.
  - Latency from tick to spike_out: 2 cycles.
  - Minimum tick spacing: 2 cycles.
- tick asserted while in ISSUE is ignored and sets tick_overrun=1, which stays set until rst.
- Events arriving during refractory are still accumulated and delivered; the neuron integrates them but cannot spike.
- nrn_spike outside ISSUE is ignored.
- With REFRACT_STEPS=0, the counter never leaves 0.
- Handshake rules:
  - The upstream source must hold ev_weight stable while ev_valid=1 and ev_ready=0.
  - No event is lost or double-counted across the ISSUE cycle.

Test Plan:
- Reset then 3 events (weights +10, +20, -5), then tick -> one cycle later nrn_enable=1 for exactly one cycle, nrn_I_syn=25, nrn_input_event=1, nrn_refract_cnt=0; ev_ready=0 during that cycle only.
- 20 events of weight +127 (V_WIDTH=12) then tick -> nrn_I_syn=2047 (saturated). Repeat with weight -128 x20 -> nrn_I_syn=-2048.
- Tick with no events -> nrn_enable pulse with nrn_I_syn=0, nrn_input_event=0. An event accepted in the same cycle as the tick (weight 7) -> nrn_I_syn=7, nrn_input_event=1, and the next step starts from 0.
- Force nrn_spike=1 during ISSUE, REFRACT_STEPS=3 -> spike_out pulse 2 cycles after tick; spike_cnt=1; nrn_refract_cnt=3, then presented as 3, 2, 1 on the next three issues and 0 on the fourth; spike_out never pulses in cycles where nrn_spike=0.
- Tick on back-to-back cycles -> second tick ignored, only one nrn_enable pulse, tick_overrun=1 and held until rst.
- Assert rst in the ISSUE cycle with acc nonzero -> next cycle all outputs 0, state ACCUM, ev_ready=1, no spike_out, spike_cnt=0.
